// File: rtl/cpu_bp_pkg.sv
// Shared types for the branch-prediction resolve path: FSM state, EX prediction slot
// and the default address width.
package cpu_bp_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic {
        NORMAL   = 1'b0,
        REDIRECT = 1'b1
    } bru_state_t;

    typedef struct packed {
        logic                valid;
        logic                pred;
        logic [XLEN_DEF-1:0] pc_plus4;
    } pred_slot_t;

endpackage

// File: rtl/branch_resolve_unit_stat_counter.sv
// Saturating event counter with enable; sticks at all-ones once full.
module bru_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment on enable unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the EX-stage prediction bit against the actual outcome and drives the fetch
// redirect and pipeline flushes. Optional statistics counters under macro BRU_STATS_EN.
module branch_resolve_unit
    import cpu_bp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_enable,
    input  logic            id_valid,
    input  logic            predict_branch_taken,
    input  logic [XLEN-1:0] PC_plus4_IFID_out,
    input  logic            ex_branch,
    input  logic            ex_jumpAL,
    input  logic            takeBranch,
    input  logic [XLEN-1:0] ex_target,
    output logic            incorrect_b_prediction,
    output logic [XLEN-1:0] branch_PC,
    output logic            flush_IFID,
    output logic            flush_IDEX,
    output logic            ex_pred
`ifdef BRU_STATS_EN
   ,output logic [CNT_W-1:0] stat_resolved,
    output logic [CNT_W-1:0] stat_mispredict
`endif
);

    // The slot struct is sized by the package constant, so the address width must match it.
    if (XLEN != XLEN_DEF) begin : g_bad_xlen
        $error("branch_resolve_unit: XLEN must equal XLEN_DEF");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("branch_resolve_unit: CNT_W must be positive");
    end

    bru_state_t      state_r;
    pred_slot_t      slot_r;
    logic [XLEN-1:0] redir_r;
    logic            is_cf_s;
    logic            mismatch_s;
    logic [XLEN-1:0] target_s;

    // Mispredict detection; a predicted-taken non-branch is a tag alias and also redirects.
    always_comb begin
        is_cf_s    = ex_branch | ex_jumpAL;
        mismatch_s = 1'b0;
        if ((state_r == NORMAL) && slot_r.valid) begin
            mismatch_s = (is_cf_s & (takeBranch != slot_r.pred)) | (~is_cf_s & slot_r.pred);
        end else begin
            mismatch_s = 1'b0;
        end
        target_s = (is_cf_s & takeBranch) ? ex_target : slot_r.pc_plus4;
    end

    // Redirect outputs: same-cycle on detection, held from registers while waiting.
    always_comb begin
        incorrect_b_prediction = 1'b0;
        branch_PC              = '0;
        flush_IFID             = 1'b0;
        flush_IDEX             = 1'b0;
        case (state_r)
            REDIRECT: begin
                incorrect_b_prediction = 1'b1;
                branch_PC              = redir_r;
                flush_IFID             = 1'b1;
                flush_IDEX             = 1'b1;
            end
            NORMAL: begin
                if (mismatch_s) begin
                    incorrect_b_prediction = 1'b1;
                    branch_PC              = target_s;
                    flush_IFID             = 1'b1;
                    flush_IDEX             = 1'b1;
                end else begin
                    incorrect_b_prediction = 1'b0;
                end
            end
            default: begin
                incorrect_b_prediction = 1'b0;
            end
        endcase
    end

    // EX slot: advances with the pipeline, becomes a bubble on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= '0;
        end else if (PC_enable) begin
            if (flush_IDEX) begin
                slot_r <= '0;
            end else begin
                slot_r <= '{valid:    id_valid,
                            pred:     predict_branch_taken & id_valid,
                            pc_plus4: PC_plus4_IFID_out};
            end
        end
    end

    // Redirect FSM: park the target when the PC register cannot take it this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= NORMAL;
            redir_r <= '0;
        end else begin
            case (state_r)
                NORMAL: begin
                    if (mismatch_s && !PC_enable) begin
                        redir_r <= target_s;
                        state_r <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (PC_enable) begin
                        redir_r <= '0;
                        state_r <= NORMAL;
                    end
                end
                default: begin
                    redir_r <= '0;
                    state_r <= NORMAL;
                end
            endcase
        end
    end

    assign ex_pred = slot_r.pred;

`ifdef BRU_STATS_EN
    logic resolved_en_s;
    logic mispredict_en_s;

    // A resolved control-flow op is counted once, on the edge it leaves EX.
    assign resolved_en_s   = PC_enable & slot_r.valid & is_cf_s;
    assign mispredict_en_s = PC_enable & incorrect_b_prediction;

    bru_stat_counter #(.W(CNT_W)) u_stat_resolved (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (resolved_en_s),
        .count (stat_resolved)
    );

    bru_stat_counter #(.W(CNT_W)) u_stat_mispredict (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mispredict_en_s),
        .count (stat_mispredict)
    );
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vector bench for branch_resolve_unit: table of single-shot resolutions plus
// hand sequences for the held redirect and reset during a redirect.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_enable;
    logic        id_valid;
    logic        predict_branch_taken;
    logic [31:0] PC_plus4_IFID_out;
    logic        ex_branch;
    logic        ex_jumpAL;
    logic        takeBranch;
    logic [31:0] ex_target;
    logic        incorrect_b_prediction;
    logic [31:0] branch_PC;
    logic        flush_IFID;
    logic        flush_IDEX;
    logic        ex_pred;
`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .PC_enable              (PC_enable),
        .id_valid               (id_valid),
        .predict_branch_taken   (predict_branch_taken),
        .PC_plus4_IFID_out      (PC_plus4_IFID_out),
        .ex_branch              (ex_branch),
        .ex_jumpAL              (ex_jumpAL),
        .takeBranch             (takeBranch),
        .ex_target              (ex_target),
        .incorrect_b_prediction (incorrect_b_prediction),
        .branch_PC              (branch_PC),
        .flush_IFID             (flush_IFID),
        .flush_IDEX             (flush_IDEX),
        .ex_pred                (ex_pred)
`ifdef BRU_STATS_EN
       ,.stat_resolved          (stat_resolved),
        .stat_mispredict        (stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        p;
        logic [31:0] pc4;
        logic        br;
        logic        jal;
        logic        tk;
        logic [31:0] tgt;
        logic        e_inc;
        logic [31:0] e_pc;
        logic        e_pred;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packs {redirect, flush_IFID, flush_IDEX}
    function automatic logic [31:0] ctl();
        return {29'd0, incorrect_b_prediction, flush_IFID, flush_IDEX};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slot(input logic v, input logic p, input logic [31:0] pc4);
        id_valid = v; predict_branch_taken = p; PC_plus4_IFID_out = pc4;
        ex_branch = 1'b0; ex_jumpAL = 1'b0; takeBranch = 1'b0; ex_target = 32'd0;
        PC_enable = 1'b1;
        next_cycle();
        id_valid = 1'b0; predict_branch_taken = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h14,       1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100,      1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h48,       1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 32'h48,       1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h2C,       1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h2C,       1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h60,       1'b0, 1'b1, 1'b1, 32'h80,  1'b0, 32'h0,        1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h64,       1'b1, 1'b0, 1'b0, 32'h90,  1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h68,       1'b1, 1'b0, 1'b1, 32'hA0,  1'b0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h10,       1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400,      1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h70,       1'b0, 1'b0, 1'b0, 32'hB0,  1'b0, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h74,       1'b1, 1'b0, 1'b1, 32'hC0,  1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h78,       1'b0, 1'b0, 1'b1, 32'hD0,  1'b0, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'hE0,  1'b1, 32'hFFFFFFFC, 1'b1};

        rst_n = 1'b0; PC_enable = 1'b0; id_valid = 1'b0; predict_branch_taken = 1'b0;
        PC_plus4_IFID_out = 32'd0; ex_branch = 1'b0; ex_jumpAL = 1'b0;
        takeBranch = 1'b0; ex_target = 32'd0;
        #12;
        check("reset_ctl", ctl(), 32'd0);
        check("reset_pc", branch_PC, 32'd0);
        check("reset_pred", {31'd0, ex_pred}, 32'd0);
`ifdef BRU_STATS_EN
        check("reset_stat_res", stat_resolved, 32'd0);
        check("reset_stat_mis", stat_mispredict, 32'd0);
`endif
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 11; i++) begin
            load_slot(vecs[i].v, vecs[i].p, vecs[i].pc4);
            ex_branch = vecs[i].br; ex_jumpAL = vecs[i].jal;
            takeBranch = vecs[i].tk; ex_target = vecs[i].tgt;
            #4;
            check($sformatf("vec%0d_ctl", i), ctl(), {29'd0, {3{vecs[i].e_inc}}});
            check($sformatf("vec%0d_pc", i), branch_PC, vecs[i].e_pc);
            check($sformatf("vec%0d_pred", i), {31'd0, ex_pred}, {31'd0, vecs[i].e_pred});
            next_cycle();
            #4;
            check($sformatf("vec%0d_after", i), ctl(), 32'd0);
            check($sformatf("vec%0d_after_pc", i), branch_PC, 32'd0);
        end

`ifdef BRU_STATS_EN
        // Resolved: vectors 0,1,3,4,5,6,10 ; accepted redirects: 0,1,2,6,10
        check("stat_resolved", stat_resolved, 32'd7);
        check("stat_mispredict", stat_mispredict, 32'd5);
`endif

        // Held redirect: PC_enable low for three cycles, accepted on the fourth
        load_slot(1'b1, 1'b0, 32'h1C);
        ex_branch = 1'b1; takeBranch = 1'b1; ex_target = 32'h200; PC_enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) PC_enable = 1'b1;
            #4;
            check($sformatf("hold%0d_ctl", c), ctl(), 32'd7);
            check($sformatf("hold%0d_pc", c), branch_PC, 32'h200);
            next_cycle();
            ex_target = 32'h999;
        end
        #4;
        check("hold_drop_ctl", ctl(), 32'd0);
        check("hold_drop_pc", branch_PC, 32'd0);
        next_cycle();
        #4;
        check("hold_nodup", ctl(), 32'd0);
`ifdef BRU_STATS_EN
        check("hold_stat_res", stat_resolved, 32'd8);
        check("hold_stat_mis", stat_mispredict, 32'd6);
`endif
        next_cycle();

        // Reset during a redirect clears outputs without a clock edge
        load_slot(1'b1, 1'b1, 32'h54);
        ex_branch = 1'b1; takeBranch = 1'b0; ex_target = 32'h700; PC_enable = 1'b0;
        next_cycle();
        ex_branch = 1'b0;
        #1;
        check("rst_pre_ctl", ctl(), 32'd7);
        check("rst_pre_pc", branch_PC, 32'h54);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", ctl(), 32'd0);
        check("rst_async_pc", branch_PC, 32'd0);
        check("rst_async_pred", {31'd0, ex_pred}, 32'd0);
        #1;
        rst_n = 1'b1;
        next_cycle();
        #4;
        check("rst_after_ctl", ctl(), 32'd0);
        check("rst_after_pc", branch_PC, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks each fetched instruction's dynamic-prediction bit from ID into EX and compares it with the actual branch/jump outcome. On a mismatch it drives the fetch-stage redirect (`incorrect_b_prediction`, `branch_PC`) and the IF/ID and ID/EX flushes. It holds the redirect until the PC register accepts it. It sits downstream of the BTB/PC fetch stage and upstream of that stage's `incorrect_b_prediction`/`branch_PC` inputs, closing the prediction loop.

## Interface
Parameters:
- `XLEN`, 32, address width.
- `CNT_W`, 32, width of the statistics counters (see Configuration).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `PC_enable`  in  1  pipeline advance / PC register load enable.
- `id_valid`  in  1  instruction in ID is real (not a bubble).
- `predict_branch_taken`  in  1  fetch-stage prediction for the instruction in ID.
- `PC_plus4_IFID_out`  in  XLEN  PC+4 of the instruction in ID.
- `ex_branch`, `ex_jumpAL`  in  1  instruction in EX is a conditional branch / JAL.
- `takeBranch`  in  1  actual outcome for EX (ignored when `ex_branch|ex_jumpAL`=0).
- `ex_target`  in  XLEN  computed branch/jump target for EX.
- `incorrect_b_prediction`  out  1  redirect fetch.
- `branch_PC`  out  XLEN  redirect address.
- `flush_IFID`, `flush_IDEX`  out  1  squash the IF/ID and ID/EX registers.
- `ex_pred`  out  1  prediction bit currently held in EX (debug/trace).

## Operation
EX slot `{valid, pred, pc_plus4}`:
- When `PC_enable`=1 and no flush: loads `{id_valid, predict_branch_taken & id_valid, PC_plus4_IFID_out}`.
- When `PC_enable`=1 and `flush_IDEX`=1: loads a bubble (all zero).
- When `PC_enable`=0: holds.

Mispredict detection, combinational. Active only when state=NORMAL and slot valid:
- `is_cf = ex_branch|ex_jumpAL`.
- Mismatch when `is_cf & (takeBranch != pred)` or `~is_cf & pred`. The second case is a tag alias that predicted taken on a non-branch.
- Target: `(is_cf & takeBranch) ? ex_target : pc_plus4`.

FSM states:
- NORMAL: on mismatch, assert `incorrect_b_prediction`, `branch_PC`=target, and both flushes in the same cycle. If `PC_enable`=1 the redirect is consumed that edge and the FSM stays NORMAL. If `PC_enable`=0, latch the target into `redir_q` and go to REDIRECT.
- REDIRECT: drive `incorrect_b_prediction`=1, `branch_PC`=`redir_q`, and both flushes from registers. No new detection occurs here; the EX slot is frozen anyway. Return to NORMAL on the first cycle with `PC_enable`=1.

Outputs when idle: `branch_PC`=0 and flushes=0 whenever `incorrect_b_prediction`=0.

## Timing
- Reset (async): state=NORMAL, EX slot=0, `redir_q`=0. All outputs 0, counters 0.
- Detection-to-redirect latency: 0 cycles. Correct PC is loaded at the EX-resolution edge when `PC_enable`=1.
- Redirect is level-held until accepted. It is never dropped and never duplicated.
- Instruction arriving in EX on the edge after a flush is a bubble; no detection on it.
- Reset asserted mid-REDIRECT: redirect abandoned, outputs 0 immediately (async).
- Correct predictions (taken or not) produce no outputs and no flush.

## Configuration
Macro `BRU_STATS_EN`.
- Defined: adds outputs `stat_resolved` and `stat_mispredict` (`CNT_W` each).
  - `stat_resolved` counts each EX-slot valid `is_cf` on an advancing edge.
  - `stat_mispredict` counts each accepted redirect.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cpu_bp_pkg`:
  - `bru_state_t` enum {NORMAL, REDIRECT}.
  - `pred_slot_t` struct {valid, pred, pc_plus4}.
  - `XLEN_DEF` constant.
- One sub-module, `bru_stat_counter`: a saturating counter with enable, instantiated twice under `BRU_STATS_EN`.

## Test plan
- Slot valid pred=0, `ex_branch`=1, `takeBranch`=1, `ex_target`=0x100, `PC_enable`=1 -> same cycle `incorrect_b_prediction`=1, `branch_PC`=0x100, both flushes=1. Next cycle all 0.
- pred=1, `ex_branch`=1, `takeBranch`=0, `pc_plus4`=0x48 -> `branch_PC`=0x48 for one cycle.
- pred=1, non-branch (alias), `pc_plus4`=0x2C -> redirect to 0x2C.
- Mispredict to 0x200 with `PC_enable`=0 for 3 cycles -> outputs held 4 cycles (0x200, flushes=1). Drop to 0 the cycle after `PC_enable` returns to 1.
- pred=1, `ex_jumpAL`=1, `takeBranch`=1 -> no redirect, no flush. With `BRU_STATS_EN`: `stat_resolved`+1, `stat_mispredict` unchanged.
- `rst_n` pulsed low while in REDIRECT -> outputs 0 without waiting for a clock edge, then state NORMAL.
